led_pio_scheduler: RTL
======================

// Module: led_pio_scheduler
// PURPOSE
//  Sequences and arbitrates all writes to the 8-bit LED PIO slave (register at offset 0).
//  - Two requesters share the PIO: a host one-shot write port and an internal periodic pattern engine.
//  - Acts as the sole Avalon-MM master in front of the PIO, so the two requesters never collide.
// PARAMETERS
//  WIDTH     8           LED/pattern width; writedata upper bits driven 0
//  PERIOD    25_000_000  clk cycles per pattern tick (>=2)
//  PAT_INIT  8'h01       pattern register reset value
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      reset; synchronous, active-low
//  enable_i       in   1      1 = pattern engine runs; 0 = tick counter held at 0
//  mode_i         in   2      00 hold, 01 rotate-left, 10 invert (blink), 11 increment
//  req_i          in   1      host write request; level, held until ack_o
//  req_data_i     in   WIDTH  host pattern; stable while req_i=1
//  ack_o          out  1      1-cycle pulse: host write completed
//  overrun_o      out  1      sticky: a tick arrived while the previous auto write was still pending
//  err_o          out  1      sticky readback mismatch (see CONFIGURATION)
//  pattern_o      out  WIDTH  last value written to the PIO
//  avm_address    out  2      PIO address; always 0
//  avm_chipselect out  1      PIO chipselect
//  avm_write_n    out  1      PIO write strobe, active-low
//  avm_writedata  out  32     {zeros, pattern}
//  avm_readdata   in   32     PIO readdata; combinational from the slave
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE, tick counter=0, pattern=PAT_INIT, pattern_o=PAT_INIT.
//  - Reset also clears pend flags, ack_o, overrun_o and err_o.
//  - Reset drives avm_chipselect=0, avm_write_n=1, avm_writedata=0.
//  - Reset mid-transfer aborts the transfer; no ack is issued.
//  Tick: counter counts 0..PERIOD-1 and wraps; tick = (counter==PERIOD-1) && enable_i.
//  - tick && mode_i!=00 sets auto_pend.
//  - If auto_pend is already 1 when a tick arrives, overrun_o is set and the tick is dropped.
//  - enable_i=0 clears the counter and auto_pend. The host path is unaffected.
//  FSM: IDLE -> WRITE -> [VERIFY] -> DONE -> IDLE.
//  - IDLE grant: req_i wins over auto_pend. Host and tick in the same cycle: host first, auto_pend retained.
//  - On grant, latch wdata: host -> req_data_i; auto -> next(pattern).
//    next() = rotl1 / ~p / p+1 (mod 2^WIDTH), per mode_i sampled at the grant cycle.
//  - WRITE (exactly 1 cycle): avm_chipselect=1, avm_write_n=0, avm_writedata=wdata.
//    pattern and pattern_o are updated with wdata at the end of this cycle.
//  - A host write reloads pattern, so the auto sequence continues from the host value.
//  - DONE: avm_chipselect=0. Host grant: ack_o=1 for this cycle only. Auto grant: auto_pend cleared.
//  - req_i is sampled only in IDLE. The requester drops req_i in the cycle after ack_o.
//  Latency (no readback): req_i seen in IDLE cycle n -> write strobe at n+1 -> ack_o at n+2.
//  - Back-to-back spacing: 3 cycles.
//  - Outside WRITE/VERIFY: avm_chipselect=0, avm_write_n=1.
//  - mode_i changes take effect at the next grant; the counter is not disturbed.
// CONFIGURATION
//  LED_SCHED_READBACK_EN defined:
//  - VERIFY state is inserted after WRITE: avm_chipselect=1, avm_write_n=1, address 0.
//  - In VERIFY, avm_readdata[WIDTH-1:0] is compared with wdata; a mismatch sets err_o (sticky).
//  - All latencies grow by 1 cycle (ack_o at n+3).
//  LED_SCHED_READBACK_EN undefined:
//  - No VERIFY state; err_o is tied 0.
//  - avm_readdata port is kept but ignored.
// TESTING
//  1 Reset: hold reset_n=0 for 2 clks -> pattern_o=8'h01, avm_write_n=1, ack_o=0, overrun_o=0, err_o=0.
//  2 PERIOD=4, enable_i=1, mode=01 -> one write each 4 clks: 02,04,...,80,01 (wrap); rotl1 so no 00.
//  3 Host: req_i=1, req_data_i=8'hA5 in IDLE at n -> writedata=A5 at n+1, ack_o at n+2.
//    Then mode=11 next auto write = A6.
//  4 req_i and tick in the same IDLE cycle (mode=10, pattern=0F).
//    -> host write first; auto write (~host data) follows 3 cycles later.
//  5 PERIOD=2 with req_i held high continuously -> overrun_o sets and stays 1; enable_i=0 clears the counter.
//  6 READBACK_EN: slave model returns writedata^8'h01 -> err_o=1 after the first VERIFY.
//    Same test without the macro -> err_o stays 0.

Source files
------------

// File: rtl/led_pio_scheduler.sv
// led_pio_scheduler
// Sole Avalon-MM master in front of an 8-bit LED PIO (register offset 0).
// Arbitrates a host one-shot write port against an internal periodic
// pattern engine so the two never collide on the slave.
// Optional feature: define LED_SCHED_READBACK_EN to insert a VERIFY read
// cycle after every write; a readback mismatch sets the sticky err_o.
module led_pio_scheduler #(
  parameter int               WIDTH    = 8,
  parameter int               PERIOD   = 25_000_000,
  parameter logic [WIDTH-1:0] PAT_INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] req_data_i,
  output logic             ack_o,
  output logic             overrun_o,
  output logic             err_o,
  output logic [WIDTH-1:0] pattern_o,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    tick_cnt;
  logic             auto_pend;
  logic             overrun;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] next_pat;
  logic             host_sel;
  logic             grant_host;
  logic             grant_auto;
  logic             done_auto;
  logic             tick_req;

  assign avm_address = 2'b00;
  assign pattern_o   = pattern;
  assign overrun_o   = overrun;
  assign tick_req    = (tick_cnt == CW'(PERIOD - 1)) && enable_i && (mode_i != 2'b00);

  // Next auto pattern from the current pattern and the mode seen this cycle.
  always_comb begin
    next_pat = pattern;
    case (mode_i)
      2'b01:   next_pat = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      2'b10:   next_pat = ~pattern;
      2'b11:   next_pat = pattern + WIDTH'(1);
      default: next_pat = pattern;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and bus/handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt      = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 32'h0;
    ack_o          = 1'b0;
    grant_host     = 1'b0;
    grant_auto     = 1'b0;
    done_auto      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          grant_host = 1'b1;
          state_nxt  = S_WRITE;
        end else if (auto_pend) begin
          grant_auto = 1'b1;
          state_nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {{(32-WIDTH){1'b0}}, wdata};
`ifdef LED_SCHED_READBACK_EN
        state_nxt      = S_VERIFY;
`else
        state_nxt      = S_DONE;
`endif
      end
      S_VERIFY: begin
        avm_chipselect = 1'b1;
        state_nxt      = S_DONE;
      end
      S_DONE: begin
        ack_o     = host_sel;
        done_auto = ~host_sel;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the granted write data and commit it to the pattern after the strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdata    <= '0;
      host_sel <= 1'b0;
      pattern  <= PAT_INIT;
    end else begin
      if (grant_host) begin
        wdata    <= req_data_i;
        host_sel <= 1'b1;
      end else if (grant_auto) begin
        wdata    <= next_pat;
        host_sel <= 1'b0;
      end
      if (state == S_WRITE) pattern <= wdata;
    end
  end

  // Tick counter, pending auto request and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      auto_pend <= 1'b0;
      overrun   <= 1'b0;
    end else if (!enable_i) begin
      tick_cnt  <= '0;
      auto_pend <= 1'b0;
    end else begin
      tick_cnt  <= (tick_cnt == CW'(PERIOD - 1)) ? '0 : tick_cnt + CW'(1);
      if (tick_req && auto_pend) overrun <= 1'b1;
      // A tick landing while a request is still pending is dropped.
      auto_pend <= (auto_pend && !done_auto) || (tick_req && !auto_pend);
    end
  end

`ifdef LED_SCHED_READBACK_EN
  logic err_q;

  // Compare the slave readback against the data just written.
  always_ff @(posedge clk) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if ((state == S_VERIFY) && (avm_readdata[WIDTH-1:0] != wdata))
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Readdata upper bits (and all bits without readback) are intentionally unused.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;

endmodule
